// File: rtl/mf_run_sequencer.sv
// Sequences one matched-filter run: tap load from the selected reference ROM,
// reversed sample stream into the filters, pipeline flush, done pulse.
module mf_run_sequencer #(
  parameter int ORDER        = 60,
  parameter int ADDR_W       = 6,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        sig_sel,
  input  logic              det_r,
  input  logic              det_i,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [2:0]        ref_en,
  output logic              load_h,
  output logic [ADDR_W-1:0] x_addr,
  output logic              x_en,
  output logic              mf_start,
  output logic              busy,
  output logic              done,
  output logic              sel_err,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_pos
);

  localparam int KMAX = (ORDER > FLUSH_CYCLES) ? ORDER : FLUSH_CYCLES;
  localparam int KW   = $clog2(KMAX + 1);

  localparam logic [KW-1:0]     K_LAST_RUN   = KW'(ORDER - 1);
  localparam logic [KW-1:0]     K_LAST_FLUSH = KW'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] A_LAST       = ADDR_W'(ORDER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [2:0]        sel_q, sel_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] hit_pos_q, hit_pos_d;
  logic              sel_err_q, sel_err_d;

  logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
  logic [2:0]        ref_en_q, ref_en_d;
  logic              load_h_q, load_h_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic              x_en_q, x_en_d;
  logic              mf_start_q, mf_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic det_any;
  assign det_any = det_r | det_i;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sel_d     = sel_q;
    hit_d     = hit_q;
    hit_pos_d = hit_pos_q;
    sel_err_d = 1'b0;

    // abort overrides every transition and suppresses detection capture
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if ($onehot(sig_sel)) begin
              sel_d     = sig_sel;
              hit_d     = 1'b0;
              hit_pos_d = '0;
              k_d       = '0;
              state_d   = S_LOAD;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (k_q == K_LAST_RUN) begin
            k_d     = '0;
            state_d = S_STREAM;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        S_STREAM: begin
          if (det_any && !hit_q) begin
            hit_d     = 1'b1;
            hit_pos_d = ADDR_W'(k_q);
          end
          if (k_q == K_LAST_RUN) begin
            k_d     = '0;
            state_d = S_FLUSH;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        S_FLUSH: begin
          if (det_any && !hit_q) begin
            hit_d     = 1'b1;
            hit_pos_d = A_LAST;
          end
          if (k_q == K_LAST_FLUSH) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    ref_addr_d = '0;
    ref_en_d   = '0;
    load_h_d   = 1'b0;
    x_addr_d   = '0;
    x_en_d     = 1'b0;
    mf_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      S_LOAD: begin
        ref_addr_d = ADDR_W'(k_d);
        ref_en_d   = sel_d;
        load_h_d   = 1'b1;
        busy_d     = 1'b1;
      end
      S_STREAM: begin
        ref_addr_d = A_LAST;
        ref_en_d   = sel_d;
        x_addr_d   = A_LAST - ADDR_W'(k_d);
        x_en_d     = 1'b1;
        mf_start_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_FLUSH: begin
        ref_addr_d = A_LAST;
        ref_en_d   = sel_d;
        mf_start_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      hit_pos_q  <= '0;
      sel_err_q  <= 1'b0;
      ref_addr_q <= '0;
      ref_en_q   <= '0;
      load_h_q   <= 1'b0;
      x_addr_q   <= '0;
      x_en_q     <= 1'b0;
      mf_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sel_q      <= sel_d;
      hit_q      <= hit_d;
      hit_pos_q  <= hit_pos_d;
      sel_err_q  <= sel_err_d;
      ref_addr_q <= ref_addr_d;
      ref_en_q   <= ref_en_d;
      load_h_q   <= load_h_d;
      x_addr_q   <= x_addr_d;
      x_en_q     <= x_en_d;
      mf_start_q <= mf_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ref_addr = ref_addr_q;
  assign ref_en   = ref_en_q;
  assign load_h   = load_h_q;
  assign x_addr   = x_addr_q;
  assign x_en     = x_en_q;
  assign mf_start = mf_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_err  = sel_err_q;
  assign hit      = hit_q;
  assign hit_pos  = hit_pos_q;

endmodule

// File: tb/tb_mf_run_sequencer.sv
// Directed bench for mf_run_sequencer: cycle-exact run timing, select handling,
// detection capture, abort and asynchronous reset.
module tb_mf_run_sequencer;

  localparam int ORDER  = 60;
  localparam int ADDR_W = 6;
  localparam int FLUSH  = 4;
  localparam int RUNLEN = 2 * ORDER + FLUSH + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        sig_sel = 3'b000;
  logic              det_r = 1'b0;
  logic              det_i = 1'b0;
  logic [ADDR_W-1:0] ref_addr;
  logic [2:0]        ref_en;
  logic              load_h;
  logic [ADDR_W-1:0] x_addr;
  logic              x_en;
  logic              mf_start;
  logic              busy;
  logic              done;
  logic              sel_err;
  logic              hit;
  logic [ADDR_W-1:0] hit_pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mf_run_sequencer #(.ORDER(ORDER), .ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sig_sel(sig_sel),
    .det_r(det_r), .det_i(det_i), .ref_addr(ref_addr), .ref_en(ref_en),
    .load_h(load_h), .x_addr(x_addr), .x_en(x_en), .mf_start(mf_start),
    .busy(busy), .done(done), .sel_err(sel_err), .hit(hit), .hit_pos(hit_pos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] obs();
    return {ref_addr, ref_en, load_h, x_addr, x_en, mf_start, busy, done};
  endfunction

  // i = 1 is the cycle right after the edge that accepted start
  task automatic expect_cycle(input int i, input logic [2:0] sel);
    logic [5:0] ra, xa;
    logic [2:0] re;
    logic       lh, xe, ms, bz, dn;
    ra = '0; xa = '0; re = '0; lh = 0; xe = 0; ms = 0; bz = 0; dn = 0;
    if (i <= ORDER) begin
      ra = 6'(i - 1); re = sel; lh = 1; bz = 1;
    end else if (i <= 2 * ORDER) begin
      ra = 6'(ORDER - 1); xa = 6'(2 * ORDER - i); re = sel; xe = 1; ms = 1; bz = 1;
    end else if (i <= 2 * ORDER + FLUSH) begin
      ra = 6'(ORDER - 1); re = sel; ms = 1; bz = 1;
    end else if (i == RUNLEN) begin
      dn = 1;
    end
    check($sformatf("cyc%0d_sel%0b", i, sel), 32'(obs()), 32'({ra, re, lh, xa, xe, ms, bz, dn}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [2:0] sel);
    sig_sel = sel;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_outs", 32'(obs()), 32'd0);
    check("rst_flags", {29'd0, sel_err, hit, 1'b0}, 32'd0);
    check("rst_hitpos", 32'(hit_pos), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    check("idle_outs", 32'(obs()), 32'd0);

    // chirp run, no detections
    start_run(3'b010);
    for (int i = 1; i <= RUNLEN + 1; i++) begin
      expect_cycle(i, 3'b010);
      step();
    end
    check("chirp_hit", 32'(hit), 32'd0);

    // sine run: det_r at stream k=17, det_i at k=30
    start_run(3'b001);
    for (int i = 1; i <= RUNLEN + 1; i++) begin
      expect_cycle(i, 3'b001);
      if (i == 78) check("det_prehit", 32'(hit), 32'd0);
      if (i == 79) check("det_hitpos", 32'(hit_pos), 32'd17);
      det_r = (i == 78);
      det_i = (i == 91);
      step();
    end
    det_r = 0; det_i = 0;
    check("det_hit", 32'(hit), 32'd1);
    check("det_hitpos_end", 32'(hit_pos), 32'd17);

    // invalid selects: multi-hot then zero
    start_run(3'b011);
    check("selerr_011", {29'd0, sel_err, busy, 1'b0}, 32'b100);
    check("selerr_011_en", 32'(ref_en), 32'd0);
    step();
    check("selerr_011_clr", {30'd0, sel_err, busy}, 32'd0);
    start_run(3'b000);
    check("selerr_000", {29'd0, sel_err, busy, 1'b0}, 32'b100);
    step();
    check("selerr_000_clr", {30'd0, sel_err, busy}, 32'd0);
    check("selerr_hitkeep", {25'd0, hit, hit_pos}, {25'd0, 1'b1, 6'd17});

    // chirp run with select change and re-start in LOAD k=10; hit cleared
    start_run(3'b010);
    check("restart_hitclr", {25'd0, hit, hit_pos}, 32'd0);
    for (int i = 1; i <= RUNLEN + 1; i++) begin
      expect_cycle(i, 3'b010);
      if (i == 11) begin sig_sel = 3'b100; start = 1'b1; end
      else start = 1'b0;
      step();
    end
    start = 1'b0;

    // abort at stream k=25 together with a detection
    start_run(3'b010);
    for (int i = 1; i <= 86; i++) begin
      expect_cycle(i, 3'b010);
      if (i < 86) step();
    end
    abort = 1'b1; det_r = 1'b1;
    step();
    abort = 1'b0; det_r = 1'b0;
    check("abort_outs", 32'(obs()), 32'd0);
    check("abort_nohit", 32'(hit), 32'd0);
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("abort_idle%0d", j), {30'd0, done, busy}, 32'd0);
    end

    // abort together with start in IDLE: start ignored
    sig_sel = 3'b001; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", 32'(obs()), 32'd0);

    // full run after abort; detection inside FLUSH reports ORDER-1
    start_run(3'b001);
    for (int i = 1; i <= RUNLEN + 1; i++) begin
      expect_cycle(i, 3'b001);
      det_i = (i == 122);
      step();
    end
    det_i = 1'b0;
    check("flush_hit", {25'd0, hit, hit_pos}, {25'd0, 1'b1, 6'd59});

    // async reset mid-FLUSH, between edges
    start_run(3'b010);
    for (int i = 1; i <= 122; i++) begin
      expect_cycle(i, 3'b010);
      step();
    end
    #2 rst = 1'b0;
    #1;
    check("arst_outs", 32'(obs()), 32'd0);
    check("arst_flags", {24'd0, sel_err, hit, hit_pos}, 32'd0);
    #1;
    sig_sel = 3'b100; start = 1'b1;
    #1 rst = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= RUNLEN + 1; i++) begin
      expect_cycle(i, 3'b100);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mf_run_sequencer.md
Name: mf_run_sequencer

Overview:
- Controller that sequences one matched-filter run for the real/imag filter pair.
- Latches a one-hot reference-waveform select and enables exactly one reference ROM bank (sine / chirp / triangle).
- Steps the reference address 0..ORDER-1 to load taps, then streams incoming-sample addresses ORDER-1 down to 0 while asserting the filter start strobe, then drains the filter pipeline.
- Captures the first detection event and its sample position; replaces free-running address counters and the unarbitrated multi-driver reference select.

Parameters:
- ORDER, 60, filter length = number of taps = number of incoming samples per run.
- ADDR_W, 6, ROM address width; ORDER must be ≤ 2^ADDR_W.
- FLUSH_CYCLES, 4, cycles after the last sample before run completes; must be ≥ 1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled each cycle in IDLE.
- abort  in  1  synchronous abort, any state.
- sig_sel  in  3  one-hot waveform select: [0] sine, [1] chirp, [2] triangle.
- det_r  in  1  detection flag, real filter.
- det_i  in  1  detection flag, imag filter.
- ref_addr  out  ADDR_W  reference ROM address.
- ref_en  out  3  one-hot reference ROM bank enable.
- load_h  out  1  tap-load strobe to filters.
- x_addr  out  ADDR_W  incoming-sample ROM address.
- x_en  out  1  incoming ROM enable.
- mf_start  out  1  filter start_signal.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.
- sel_err  out  1  one-cycle pulse: start rejected, select invalid.
- hit  out  1  detection captured in last/current run.
- hit_pos  out  ADDR_W  sample index k (0-based stream count) at first detection.

Behaviour:
- Reset: all outputs 0; state IDLE; latched select 0; counter 0.
- States: IDLE, LOAD, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 with sig_sel exactly one-hot: latch sig_sel, clear hit/hit_pos, counter k=0, go to LOAD.
  - start=1 with sig_sel zero or multi-hot: sel_err=1 for one cycle, stay in IDLE, hit unchanged.
- LOAD (ORDER cycles):
  - ref_en = latched select; load_h=1; ref_addr=k for k=0..ORDER-1.
  - After k=ORDER-1, go to STREAM with k=0.
- STREAM (ORDER cycles):
  - x_en=1, mf_start=1, x_addr=ORDER-1-k.
  - ref_addr holds ORDER-1; ref_en stays asserted; load_h=0.
  - After k=ORDER-1, go to FLUSH with k=0.
- FLUSH (FLUSH_CYCLES cycles):
  - mf_start=1, x_en=0, x_addr holds 0.
  - Then go to DONE.
- DONE (1 cycle): done=1, busy=0, ref_en=0, mf_start=0; then IDLE.
- busy=1 in LOAD, STREAM and FLUSH only.
- Outputs are registered. With start sampled at edge N: LOAD spans cycles N+1..N+ORDER; STREAM N+ORDER+1..N+2·ORDER; FLUSH next FLUSH_CYCLES cycles; DONE next cycle.
- Detection:
  - During STREAM or FLUSH, first cycle with (det_r | det_i)=1 and hit=0 sets hit=1.
  - hit_pos = k during STREAM; = ORDER-1 during FLUSH.
  - Later detections are ignored; hit holds through IDLE until the next accepted start.
- start while busy: ignored.
- sig_sel changes mid-run: ignored (latched copy used).
- abort=1 in any non-IDLE state: next cycle IDLE; all strobes and enables 0; no done pulse; hit/hit_pos keep current values.
- abort has priority over every other transition. abort with start in IDLE: start ignored.
- Simultaneous det and abort: abort wins, detection not captured.
- Counter k is sized ceil(log2(max(ORDER, FLUSH_CYCLES)+1)) bits; no wrap is possible within a state.

Test Plan:
- Chirp run, sig_sel=3'b010, start pulse at edge N, no detections:
  - ref_en=3'b010 and load_h=1 for N+1..N+60, ref_addr 0→59.
  - x_addr 59→0 with mf_start=1 for N+61..N+120.
  - Flush N+121..N+124; done=1 only at N+125; busy=1 N+1..N+124; hit=0.
- Invalid selects: sig_sel=3'b011, then 3'b000, each with start → sel_err single pulse each, busy stays 0, ref_en=0.
- Detection capture: sine run, det_r=1 at stream k=17, det_i=1 at k=30 → hit=1, hit_pos=17. Next accepted start clears hit.
- Abort mid-STREAM at k=25 → next cycle busy=0, mf_start=0, x_en=0, no done. A following start runs a full 125-cycle sequence.
- Select change and re-start during run: change sig_sel to 3'b100 and pulse start at LOAD k=10 → ref_en remains 3'b010, timing unchanged.
- Async reset: assert rst low mid-FLUSH, between clock edges → all outputs 0 immediately; after release, IDLE with start honoured on the first edge.
